// File: rtl/axi4lite_reg_slave_if.sv
// AXI4-Lite signal bundle between a bus master and the register-bank slave.
// Clock and reset stay plain ports on the modules that use this bundle.
interface axi4lite_reg_slave_if;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        WVALID;
  logic        WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite responder exposing a bank of byte-strobed 32-bit control registers,
// with independent write (AW/W/B) and read (AR/R) paths and SLVERR on unmapped words.
module axi4lite_reg_slave #(
  parameter int unsigned NUM_REGS    = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  axi4lite_reg_slave_if.slave       axi,
  output logic [32*NUM_REGS-1:0]    reg_out,
  output logic [NUM_REGS-1:0]       wr_pulse
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_COMMIT = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} rstate_t;

  wstate_t     wstate, wstate_n;
  rstate_t     rstate, rstate_n;

  logic [31:0] regs   [NUM_REGS];
  logic [31:0] regs_n [NUM_REGS];

  logic        aw_held, aw_held_n, w_held, w_held_n;
  logic [29:0] aw_idx, aw_idx_n;
  logic [31:0] w_data, w_data_n;
  logic [3:0]  w_strb, w_strb_n;
  logic        awready, awready_n, wready, wready_n;
  logic        bvalid, bvalid_n;
  logic [1:0]  bresp, bresp_n;
  logic [NUM_REGS-1:0] wr_pulse_n;

  logic        arready, arready_n, rvalid, rvalid_n;
  logic [31:0] rdata, rdata_n;
  logic [1:0]  rresp, rresp_n;

  logic        aw_hs, w_hs, ar_hs, aw_held_set, w_held_set;
  logic        aw_mapped, ar_mapped;
  logic [29:0] ar_idx;
  logic [IDX_W-1:0] aw_sel, ar_sel;

  // Protection bits and byte offsets within a word carry no meaning here.
  logic unused;
  assign unused = ^{axi.AWPROT, axi.ARPROT, axi.AWADDR[1:0], axi.ARADDR[1:0]};

  assign aw_hs       = axi.AWVALID && awready;
  assign w_hs        = axi.WVALID && wready;
  assign ar_hs       = axi.ARVALID && arready;
  assign aw_held_set = aw_held || aw_hs;
  assign w_held_set  = w_held || w_hs;

  assign aw_mapped = aw_idx < 30'(NUM_REGS);
  assign aw_sel    = aw_idx[IDX_W-1:0];
  assign ar_idx    = axi.ARADDR[31:2];
  assign ar_mapped = ar_idx < 30'(NUM_REGS);
  assign ar_sel    = ar_idx[IDX_W-1:0];

  // Write FSM state register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) wstate <= W_IDLE;
    else          wstate <= wstate_n;
  end

  // Write FSM next state: commit as soon as both address and data are held.
  always_comb begin
    wstate_n = wstate;
    unique case (wstate)
      W_IDLE:   if (aw_held_set && w_held_set) wstate_n = W_COMMIT;
      W_COMMIT: wstate_n = W_RESP;
      W_RESP:   if (axi.BREADY) wstate_n = W_IDLE;
      default:  wstate_n = W_IDLE;
    endcase
  end

  // Write FSM outputs and register-bank update, registered on the next edge.
  always_comb begin
    aw_held_n  = aw_held;
    w_held_n   = w_held;
    aw_idx_n   = aw_idx;
    w_data_n   = w_data;
    w_strb_n   = w_strb;
    awready_n  = 1'b0;
    wready_n   = 1'b0;
    bvalid_n   = bvalid;
    bresp_n    = bresp;
    wr_pulse_n = '0;
    regs_n     = regs;
    unique case (wstate)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_n = 1'b1;
          aw_idx_n  = axi.AWADDR[31:2];
        end
        if (w_hs) begin
          w_held_n = 1'b1;
          w_data_n = axi.WDATA;
          w_strb_n = axi.WSTRB;
        end
        awready_n = !aw_held_set;
        wready_n  = !w_held_set;
      end
      W_COMMIT: begin
        bvalid_n = 1'b1;
        bresp_n  = aw_mapped ? RESP_OKAY : RESP_SLVERR;
        if (aw_mapped && (|w_strb)) begin
          wr_pulse_n[aw_sel] = 1'b1;
          for (int unsigned b = 0; b < 4; b++) begin
            if (w_strb[b]) regs_n[aw_sel][8*b +: 8] = w_data[8*b +: 8];
          end
        end
      end
      W_RESP: begin
        if (axi.BREADY) begin
          bvalid_n  = 1'b0;
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
          awready_n = 1'b1;
          wready_n  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) rstate <= R_IDLE;
    else          rstate <= rstate_n;
  end

  // Read FSM next state.
  always_comb begin
    rstate_n = rstate;
    unique case (rstate)
      R_IDLE:  if (ar_hs) rstate_n = R_RESP;
      R_RESP:  if (axi.RREADY) rstate_n = R_IDLE;
      default: rstate_n = R_IDLE;
    endcase
  end

  // Read FSM outputs; data is captured from the bank before any same-edge write lands.
  always_comb begin
    arready_n = 1'b0;
    rvalid_n  = rvalid;
    rdata_n   = rdata;
    rresp_n   = rresp;
    unique case (rstate)
      R_IDLE: begin
        if (ar_hs) begin
          rvalid_n = 1'b1;
          rdata_n  = ar_mapped ? regs[ar_sel] : 32'h0;
          rresp_n  = ar_mapped ? RESP_OKAY : RESP_SLVERR;
        end else begin
          arready_n = 1'b1;
        end
      end
      R_RESP: begin
        if (axi.RREADY) begin
          rvalid_n  = 1'b0;
          arready_n = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and bus-output registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      wr_pulse <= '0;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
    end else begin
      aw_held  <= aw_held_n;
      w_held   <= w_held_n;
      aw_idx   <= aw_idx_n;
      w_data   <= w_data_n;
      w_strb   <= w_strb_n;
      awready  <= awready_n;
      wready   <= wready_n;
      bvalid   <= bvalid_n;
      bresp    <= bresp_n;
      wr_pulse <= wr_pulse_n;
      arready  <= arready_n;
      rvalid   <= rvalid_n;
      rdata    <= rdata_n;
      rresp    <= rresp_n;
      regs     <= regs_n;
    end
  end

  assign axi.AWREADY = awready;
  assign axi.WREADY  = wready;
  assign axi.BVALID  = bvalid;
  assign axi.BRESP   = bresp;
  assign axi.ARREADY = arready;
  assign axi.RVALID  = rvalid;
  assign axi.RDATA   = rdata;
  assign axi.RRESP   = rresp;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
    assign reg_out[32*i +: 32] = regs[i];
  end

endmodule

// File: doc/axi4lite_reg_slave.md
Name: axi4lite_reg_slave

Overview:
Synthesizable AXI4-Lite responder that terminates the AXI4Lite master-side traffic driven by the testbench BFMs. It exposes a bank of 32-bit control registers to the DSI core. It accepts AW and W independently, performs byte-strobed writes and returns B/R responses with SLVERR for unmapped addresses. Register contents and per-register write strobes are exported to core logic.

Parameters:
NUM_REGS  8  number of 32-bit registers, word-addressed from offset 0 (1..256)
RESET_VALUE  32'h0000_0000  reset value of every register

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
AWADDR  in  32  write byte address
AWPROT  in  3  ignored
WVALID  in  1  write data valid
WREADY  out  1  write data ready
WDATA  in  32  write data
WSTRB  in  4  byte-lane enables
BVALID  out  1  write response valid
BREADY  in  1  write response ready
BRESP  out  2  write response, 00 OKAY / 10 SLVERR
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
ARADDR  in  32  read byte address
ARPROT  in  3  ignored
RVALID  out  1  read data valid
RREADY  in  1  read data ready
RDATA  out  32  read data
RRESP  out  2  read response, 00 OKAY / 10 SLVERR
reg_out  out  32*NUM_REGS  register contents; reg i at bits [32*i+31:32*i]
wr_pulse  out  NUM_REGS  one-cycle pulse on the edge register i is written

Behaviour:
- Reset (ARESETn low, asynchronous): all READY/VALID outputs 0; BRESP, RRESP, RDATA 0; wr_pulse 0; every register = RESET_VALUE; AW/W holding flags cleared. In-flight transactions are discarded.
- READY outputs are registered. They first rise on the first ACLK edge after ARESETn deasserts.
- Decode: index = ADDR[31:2]; ADDR[1:0] ignored. index >= NUM_REGS means unmapped.
- Write path, three-state FSM: W_IDLE, W_COMMIT, W_RESP.
  - W_IDLE: AWREADY = !aw_held; WREADY = !w_held.
    - AW handshake latches AWADDR and sets aw_held; AWREADY drops next cycle.
    - W handshake latches WDATA/WSTRB and sets w_held.
    - AW and W may arrive in the same cycle or in either order, any gap apart.
  - Once both are held (including the same-edge case), go to W_COMMIT with AWREADY=WREADY=0.
  - W_COMMIT, one cycle:
    - Mapped index: update the enabled byte lanes; lanes with WSTRB=0 are unchanged; pulse wr_pulse[index] for 1 cycle.
    - Unmapped index: no register change, no pulse, BRESP=10.
    - WSTRB=0 on a mapped address: no change and no pulse, but BRESP=00.
    - Update and BVALID=1 appear together on the edge leaving W_COMMIT. Go to W_RESP.
  - W_RESP: hold BVALID/BRESP stable until BREADY. On the BVALID&&BREADY edge: BVALID=0, holding flags cleared, AWREADY=WREADY=1, return to W_IDLE.
  - Latency: both handshakes at edge k → register updated and BVALID high at edge k+1. BREADY tied high gives one write per 3 cycles.
- Read path, two states: R_IDLE, R_RESP.
  - R_IDLE: ARREADY=1.
  - AR handshake at edge k: RVALID=1 and RDATA/RRESP registered at edge k+1, ARREADY=0.
    - Mapped: RDATA = register value as of edge k, RRESP=00.
    - Unmapped: RDATA=0, RRESP=10.
  - R_RESP: RDATA/RRESP stable until RREADY. On the RVALID&&RREADY edge: RVALID=0, ARREADY=1.
- Simultaneous read and write:
  - The read and write paths are fully independent.
  - A read accepted on the same edge as a W_COMMIT update returns the pre-write value.
  - A read accepted one edge later returns the new value.
- VALID never depends combinationally on READY. No outputs are combinational from inputs.

Test Plan:
- Reset, then AW+W same cycle to 0x04 with WDATA=0xDEADBEEF, WSTRB=0xF → reg 1 = 0xDEADBEEF one edge later; wr_pulse[1] high 1 cycle; BVALID with BRESP=00; read 0x04 returns 0xDEADBEEF, RRESP=00.
- W sent 3 cycles before AW (addr 0x08, data 0x11223344, WSTRB=0x5) on reg = 0 → WREADY low after W; reg 2 = 0x00220044 after AW; exactly one B.
- Write to 0x20 and read from 0x3C with NUM_REGS=8 → BRESP=10 and no register change or wr_pulse; RDATA=0, RRESP=10.
- BREADY held low 10 cycles after a write → BVALID/BRESP stable; AWREADY/WREADY stay 0; a second AW offered is not accepted until the cycle after the B handshake.
- Reg 3 = 0xAAAA0000; read 0x0C accepted on the same edge its write of 0x5555 commits → returns 0xAAAA0000; an immediate re-read returns 0x00005555. RREADY low 5 cycles keeps RDATA stable.
- Assert ARESETn low mid-W_RESP and mid-R_RESP → BVALID and RVALID drop without a clock edge; registers = RESET_VALUE; READYs return 1 on the first edge after release.
